// File: rtl/core_seq_pkg.sv
// Shared constants for the core instruction sequencer: phase lengths, inst bit map, FSM states.
package core_seq_pkg;

    localparam int COL      = 8;
    localparam int ROW      = 8;
    localparam int IN_W     = 6;
    localparam int K_W      = 3;
    localparam int OUT_W    = 4;
    localparam int LEN_NIJ  = IN_W * IN_W;
    localparam int LEN_KIJ  = K_W * K_W;
    localparam int LEN_ONIJ = OUT_W * OUT_W;
    localparam int W_BASE   = 1024;
    localparam int GAP_CYC  = 11;

    // Phase lengths in cycles; the *_RUN values are the lengths of the main streaming stretch.
    localparam int WFILL_LEN   = COL;
    localparam int WLOAD_RUN   = ROW + 2 * COL;
    localparam int WLOAD_LEN   = WLOAD_RUN + 2;
    localparam int AFILL_LEN   = LEN_NIJ;
    localparam int EXEC_RUN    = LEN_NIJ + ROW + COL - 1;
    localparam int EXEC_LEN    = EXEC_RUN + 3;
    localparam int ACC_PIX_LEN = LEN_KIJ + 4;

    localparam int ACC_B      = 33;
    localparam int CEN_PMEM_B = 32;
    localparam int WEN_PMEM_B = 31;
    localparam int A_PMEM_LSB = 20;
    localparam int CEN_XMEM_B = 19;
    localparam int WEN_XMEM_B = 18;
    localparam int A_XMEM_LSB = 7;
    localparam int OFIFO_RD_B = 6;
    localparam int IFIFO_WR_B = 5;
    localparam int IFIFO_RD_B = 4;
    localparam int L0_RD_B    = 3;
    localparam int L0_WR_B    = 2;
    localparam int EXECUTE_B  = 1;
    localparam int LOAD_B     = 0;

    localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

    typedef enum logic [3:0] {
        S_IDLE, S_WFILL, S_WLOAD, S_GAP, S_AFILL, S_EXEC, S_DRAIN, S_ACC, S_FIN
    } state_e;

endpackage

// File: rtl/acc_addr_gen.sv
// pmem address of the psum for output pixel onij under kernel tap k (one kij block per tap).
module acc_addr_gen
    import core_seq_pkg::*;
(
    input  logic [3:0]  onij,
    input  logic [3:0]  k,
    output logic [10:0] addr
);

    always_comb begin
        addr = 11'(LEN_NIJ * int'(k)
                 + (int'(onij) / OUT_W + int'(k) / K_W) * IN_W
                 + int'(onij) % OUT_W + int'(k) % K_W);
    end

endmodule

// File: rtl/core_inst_seq.sv
// Instruction sequencer driving core's 34-bit inst bus through all kij passes and psum accumulation.
// Optional build macro INST_SEQ_STALL_CNT_EN adds the stall_cnt output.
module core_inst_seq
    import core_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        sfu_clr,
    output logic        out_valid,
    output logic [3:0]  out_idx,
    output logic        busy,
`ifdef INST_SEQ_STALL_CNT_EN
    output logic [15:0] stall_cnt,
`endif
    output logic        done
);

    state_e      state_q, state_d;
    logic [3:0]  kij_q, kij_d;
    logic [3:0]  onij_q, onij_d;
    logic [5:0]  t_q, t_d;
    logic [33:0] inst_q, inst_d;
    logic        sfu_clr_q, sfu_clr_d;
    logic        out_valid_q, out_valid_d;
    logic [3:0]  out_idx_q, out_idx_d;
    logic        busy_q, done_q;
    logic [3:0]  acc_k;
    logic [10:0] acc_addr;

    assign acc_k = 4'(t_q - 6'd1);

    acc_addr_gen u_addr (.onij(onij_q), .k(acc_k), .addr(acc_addr));

    always_comb begin
        state_d     = state_q;
        kij_d       = kij_q;
        onij_d      = onij_q;
        t_d         = t_q + 6'd1;
        inst_d      = INST_IDLE;
        sfu_clr_d   = 1'b0;
        out_valid_d = 1'b0;
        out_idx_d   = out_idx_q;
        unique case (state_q)
            S_IDLE: begin
                t_d = '0;
                if (start) begin
                    state_d = S_WFILL;
                    kij_d   = '0;
                end
            end
            S_WFILL: begin
                inst_d[IFIFO_WR_B] = 1'b1;
                inst_d[CEN_XMEM_B] = 1'b0;
                inst_d[WEN_XMEM_B] = 1'b1;
                inst_d[A_XMEM_LSB +: 11] = 11'(W_BASE + COL * int'(kij_q) + int'(t_q));
                if (t_q == 6'(WFILL_LEN - 1)) begin
                    state_d = S_WLOAD;
                    t_d     = '0;
                end
            end
            S_WLOAD: begin
                inst_d[IFIFO_RD_B] = (t_q <= 6'(WLOAD_RUN));
                inst_d[LOAD_B]     = (t_q != 6'd0) && (t_q <= 6'(WLOAD_RUN));
                if (t_q == 6'(WLOAD_LEN - 1)) begin
                    state_d = S_GAP;
                    t_d     = '0;
                end
            end
            S_GAP: begin
                if (t_q == 6'(GAP_CYC - 1)) begin
                    state_d = S_AFILL;
                    t_d     = '0;
                end
            end
            S_AFILL: begin
                inst_d[L0_WR_B]    = 1'b1;
                inst_d[CEN_XMEM_B] = 1'b0;
                inst_d[WEN_XMEM_B] = 1'b1;
                inst_d[A_XMEM_LSB +: 11] = 11'(t_q);
                if (t_q == 6'(AFILL_LEN - 1)) begin
                    state_d = S_EXEC;
                    t_d     = '0;
                end
            end
            S_EXEC: begin
                inst_d[L0_RD_B]   = (t_q <= 6'(EXEC_RUN));
                inst_d[EXECUTE_B] = (t_q != 6'd0) && (t_q <= 6'(EXEC_RUN + 1));
                if (t_q == 6'(EXEC_LEN - 1)) begin
                    state_d = S_DRAIN;
                    t_d     = '0;
                end
            end
            S_DRAIN: begin
                // The beat index only advances when the ofifo actually has a row to hand over.
                inst_d[A_PMEM_LSB +: 11] = 11'(LEN_NIJ * int'(kij_q) + int'(t_q));
                if (ofifo_valid) begin
                    inst_d[OFIFO_RD_B] = 1'b1;
                    inst_d[CEN_PMEM_B] = 1'b0;
                    inst_d[WEN_PMEM_B] = 1'b0;
                    if (t_q == 6'(LEN_NIJ - 1)) begin
                        t_d = '0;
                        if (kij_q == 4'(LEN_KIJ - 1)) begin
                            state_d = S_ACC;
                            onij_d  = '0;
                        end else begin
                            state_d = S_WFILL;
                            kij_d   = kij_q + 4'd1;
                        end
                    end
                end else begin
                    t_d = t_q;
                end
            end
            S_ACC: begin
                // t: 0 clear, 1..LEN_KIJ reads, acc lags reads by one, result two cycles after last acc.
                sfu_clr_d = (t_q == 6'd0);
                if (t_q != 6'd0 && t_q <= 6'(LEN_KIJ)) begin
                    inst_d[CEN_PMEM_B] = 1'b0;
                    inst_d[WEN_PMEM_B] = 1'b1;
                    inst_d[A_PMEM_LSB +: 11] = acc_addr;
                end
                inst_d[ACC_B] = (t_q >= 6'd2) && (t_q <= 6'(LEN_KIJ + 1));
                if (t_q == 6'(ACC_PIX_LEN - 1)) begin
                    out_valid_d = 1'b1;
                    out_idx_d   = onij_q;
                    t_d         = '0;
                    if (onij_q == 4'(LEN_ONIJ - 1)) state_d = S_FIN;
                    else                            onij_d  = onij_q + 4'd1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
            default: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            kij_q       <= '0;
            onij_q      <= '0;
            t_q         <= '0;
            inst_q      <= INST_IDLE;
            sfu_clr_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            kij_q       <= kij_d;
            onij_q      <= onij_d;
            t_q         <= t_d;
            inst_q      <= inst_d;
            sfu_clr_q   <= sfu_clr_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_q == S_FIN);
        end
    end

`ifdef INST_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == S_IDLE && start)
            stall_cnt_d = '0;
        else if (state_q == S_DRAIN && !ofifo_valid && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign inst      = inst_q;
    assign sfu_clr   = sfu_clr_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// Bench for core_inst_seq: cycle-by-cycle compare against a phase-list model built from random ofifo_valid.
module tb_core_inst_seq;

    localparam logic [33:0] IDLE = 34'h1_800C_0000;

    logic        clk = 1'b0;
    logic        reset, start, ofifo_valid;
    logic [33:0] inst;
    logic        sfu_clr, out_valid, busy, done;
    logic [3:0]  out_idx;
`ifdef INST_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    core_inst_seq dut (
        .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
        .inst(inst), .sfu_clr(sfu_clr), .out_valid(out_valid), .out_idx(out_idx),
        .busy(busy),
`ifdef INST_SEQ_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .done(done)
    );

    typedef struct {
        logic [33:0] inst;
        logic        clr, ov, busy, done;
        logic [3:0]  idx;
    } exp_t;

    exp_t q[$];
    bit   ovs[4096];
    int   exec2_idx, n_stall;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input int j, input logic [33:0] got, input logic [33:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s[%0d] got=%h exp=%h", tag, j, got, exp);
        end
    endtask

    task automatic push(input logic [33:0] i, input bit clr, input bit ov, input int idx, input bit fin);
        exp_t e;
        e.inst = i; e.clr = clr; e.ov = ov; e.idx = 4'(idx); e.busy = !fin; e.done = fin;
        q.push_back(e);
    endtask

    // Expected per-cycle outputs, derived from the phase descriptions with plain arithmetic.
    task automatic build_model();
        logic [33:0] e;
        int beats;
        q.delete();
        n_stall = 0;
        foreach (ovs[i]) ovs[i] = ($urandom_range(0, 3) != 0);
        for (int kij = 0; kij < 9; kij++) begin
            for (int t = 0; t < 8; t++) begin
                e = IDLE; e[5] = 1; e[19] = 0; e[17:7] = 11'(1024 + kij * 8 + t);
                push(e, 0, 0, 0, 0);
            end
            e = IDLE; e[4] = 1; push(e, 0, 0, 0, 0);
            for (int t = 0; t < 24; t++) begin
                e = IDLE; e[4] = 1; e[0] = 1; push(e, 0, 0, 0, 0);
            end
            push(IDLE, 0, 0, 0, 0);
            for (int t = 0; t < 11; t++) push(IDLE, 0, 0, 0, 0);
            for (int t = 0; t < 36; t++) begin
                e = IDLE; e[2] = 1; e[19] = 0; e[17:7] = 11'(t); push(e, 0, 0, 0, 0);
            end
            if (kij == 2) exec2_idx = q.size();
            e = IDLE; e[3] = 1; push(e, 0, 0, 0, 0);
            for (int t = 0; t < 51; t++) begin
                e = IDLE; e[3] = 1; e[1] = 1; push(e, 0, 0, 0, 0);
            end
            e = IDLE; e[1] = 1; push(e, 0, 0, 0, 0);
            push(IDLE, 0, 0, 0, 0);
            beats = 0;
            while (beats < 36) begin
                e = IDLE; e[30:20] = 11'(36 * kij + beats);
                if (ovs[q.size()]) begin
                    e[6] = 1; e[32] = 0; e[31] = 0; beats++;
                end else begin
                    n_stall++;
                end
                push(e, 0, 0, 0, 0);
            end
        end
        for (int o = 0; o < 16; o++) begin
            push(IDLE, 1, 0, 0, 0);
            for (int k = 0; k < 9; k++) begin
                e = IDLE; e[32] = 0;
                e[30:20] = 11'(36 * k + (o / 4 + k / 3) * 6 + o % 4 + k % 3);
                e[33] = (k >= 1);
                push(e, 0, 0, 0, 0);
            end
            e = IDLE; e[33] = 1; push(e, 0, 0, 0, 0);
            push(IDLE, 0, 0, 0, 0);
            push(IDLE, 0, 1, o, 0);
        end
        push(IDLE, 0, 0, 0, 1);
    endtask

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 0, 34'(busy), 34'd1);
        chk("inst_after_start", 0, inst, IDLE);
    endtask

    // Drives ofifo_valid and spurious start pulses, comparing every cycle up to entry upto-1.
    task automatic run(input int upto);
        for (int j = 0; j < upto; j++) begin
            ofifo_valid = ovs[j];
            start = (j % 97 == 50);
            @(posedge clk); #1;
            chk("inst", j, inst, q[j].inst);
            chk("sfu_clr", j, 34'(sfu_clr), 34'(q[j].clr));
            chk("out_valid", j, 34'(out_valid), 34'(q[j].ov));
            chk("busy", j, 34'(busy), 34'(q[j].busy));
            chk("done", j, 34'(done), 34'(q[j].done));
            if (q[j].ov) chk("out_idx", j, 34'(out_idx), 34'(q[j].idx));
        end
        start = 1'b0;
        ofifo_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; ofifo_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_inst", 0, inst, IDLE);
        chk("rst_busy", 0, 34'(busy), 34'd0);
        chk("rst_done", 0, 34'(done), 34'd0);
        chk("rst_clr", 0, 34'(sfu_clr), 34'd0);
        chk("rst_outv", 0, 34'(out_valid), 34'd0);
        chk("rst_idx", 0, 34'(out_idx), 34'd0);

        // Full run with random drain stalls and ignored start pulses.
        build_model();
        kick();
        run(q.size());
`ifdef INST_SEQ_STALL_CNT_EN
        chk("stall_cnt", 0, 34'(stall_cnt), 34'(n_stall));
`endif
        @(posedge clk); #1;
        chk("post_done", 0, 34'(done), 34'd0);
        chk("post_busy", 0, 34'(busy), 34'd0);
        chk("post_inst", 0, inst, IDLE);

        // Abort during EXEC of kij 2; reset must win over a simultaneous start.
        build_model();
        kick();
        run(exec2_idx + 5);
        reset = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        chk("abort_inst", 0, inst, IDLE);
        chk("abort_busy", 0, 34'(busy), 34'd0);
        chk("abort_done", 0, 34'(done), 34'd0);
        reset = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        chk("abort_idle_busy", 0, 34'(busy), 34'd0);
        chk("abort_idle_inst", 0, inst, IDLE);
`ifdef INST_SEQ_STALL_CNT_EN
        chk("abort_stall_cnt", 0, 34'(stall_cnt), 34'd0);
`endif

        // Rerun from kij 0 after the abort.
        build_model();
        kick();
        run(q.size());
`ifdef INST_SEQ_STALL_CNT_EN
        chk("stall_cnt2", 0, 34'(stall_cnt), 34'(n_stall));
`endif
        @(posedge clk); #1;
        chk("post_done2", 0, 34'(done), 34'd0);
        chk("post_busy2", 0, 34'(busy), 34'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
